// File: rtl/mat_store_pkg.sv
// Shared constants, FSM encodings and slot addressing for the dual-slot matrix store.
package mat_store_pkg;
    localparam int DIM_WIDTH  = 3;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_DIM    = 5;
    localparam int SLOT_DEPTH = MAX_DIM * MAX_DIM;
    localparam int ADDR_W     = $clog2(2 * SLOT_DEPTH);

    typedef logic [DIM_WIDTH-1:0]  dim_t;
    typedef logic [DATA_WIDTH-1:0] elem_t;
    typedef logic [ADDR_W-1:0]     addr_t;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_COMMIT} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_RESP, R_HOLD}   rd_state_e;

    typedef struct packed {
        logic valid;
        dim_t m;
        dim_t n;
    } slot_meta_t;

    // Fixed stride MAX_DIM per row, slots laid out back to back.
    function automatic addr_t elem_addr(input logic slot, input dim_t row, input dim_t col);
        return (slot ? addr_t'(SLOT_DEPTH) : addr_t'(0)) + addr_t'(row) * addr_t'(MAX_DIM) + addr_t'(col);
    endfunction

    function automatic logic dims_legal(input dim_t m, input dim_t n);
        return (m != '0) && (m <= dim_t'(MAX_DIM)) && (n != '0) && (n <= dim_t'(MAX_DIM));
    endfunction
endpackage

// File: rtl/mat_store_if.sv
// Loader + engine bus of the matrix store, including the published slot metadata.
interface mat_store_if;
    import mat_store_pkg::*;

    logic  wr_start, wr_slot, wr_valid;
    dim_t  wr_m, wr_n;
    elem_t wr_elem;
    logic  wr_busy, wr_done, wr_err;

    logic  rd_en, rd_slot_idx;
    dim_t  rd_row_idx, rd_col_idx, rd_current_m, rd_current_n;
    elem_t rd_elem;
    logic  rd_elem_valid, rd_err;

    logic  slot0_valid, slot1_valid;
    dim_t  slot0_m, slot0_n, slot1_m, slot1_n;

    modport slave (
        input  wr_start, wr_slot, wr_m, wr_n, wr_valid, wr_elem,
        input  rd_en, rd_slot_idx, rd_row_idx, rd_col_idx, rd_current_m, rd_current_n,
        output wr_busy, wr_done, wr_err, rd_elem, rd_elem_valid, rd_err,
        output slot0_valid, slot0_m, slot0_n, slot1_valid, slot1_m, slot1_n
    );

    modport master (
        output wr_start, wr_slot, wr_m, wr_n, wr_valid, wr_elem,
        output rd_en, rd_slot_idx, rd_row_idx, rd_col_idx, rd_current_m, rd_current_n,
        input  wr_busy, wr_done, wr_err, rd_elem, rd_elem_valid, rd_err,
        input  slot0_valid, slot0_m, slot0_n, slot1_valid, slot1_m, slot1_n
    );
endinterface

// File: rtl/mat_store_ram.sv
// Simple 1W/1R synchronous RAM; read data register holds while re_i is low.
module mat_store_ram #(
    parameter int DEPTH = 50,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mat_store.sv
// Dual-slot matrix store: streaming row-major loader and one-shot element read responder.
module mat_store
    import mat_store_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    mat_store_if.slave bus
);
    wr_state_e  wst_q;
    logic       wslot_q, busy_q, done_q, werr_q;
    dim_t       wm_q, wn_q, wr_r_q, wr_c_q;
    slot_meta_t meta_q [2];

    rd_state_e  rst_q;
    logic       rvalid_q, rerr_q, rzero_q;

    logic       ram_we, rd_take, rd_bad;
    elem_t      ram_rdata;
    slot_meta_t rmeta;

    assign ram_we  = (wst_q == W_FILL) && bus.wr_valid;
    assign rd_take = (rst_q == R_IDLE) && bus.rd_en;
    assign rmeta   = meta_q[bus.rd_slot_idx];
    assign rd_bad  = !rmeta.valid
                   || (bus.rd_row_idx >= rmeta.m) || (bus.rd_col_idx >= rmeta.n)
                   || (bus.rd_current_m != rmeta.m) || (bus.rd_current_n != rmeta.n);

    mat_store_ram #(.DEPTH(2*SLOT_DEPTH), .AW(ADDR_W), .DW(DATA_WIDTH)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (elem_addr(wslot_q, wr_r_q, wr_c_q)),
        .wdata_i (bus.wr_elem),
        .re_i    (rd_take),
        .raddr_i (elem_addr(bus.rd_slot_idx, bus.rd_row_idx, bus.rd_col_idx)),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q   <= W_IDLE;
            wslot_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            werr_q  <= 1'b0;
            wm_q    <= '0;
            wn_q    <= '0;
            wr_r_q  <= '0;
            wr_c_q  <= '0;
            meta_q[0] <= '0;
            meta_q[1] <= '0;
        end else begin
            done_q <= 1'b0;
            werr_q <= 1'b0;
            case (wst_q)
                W_IDLE: if (bus.wr_start) begin
                    if (dims_legal(bus.wr_m, bus.wr_n)) begin
                        wslot_q <= bus.wr_slot;
                        wm_q    <= bus.wr_m;
                        wn_q    <= bus.wr_n;
                        wr_r_q  <= '0;
                        wr_c_q  <= '0;
                        busy_q  <= 1'b1;
                        meta_q[bus.wr_slot].valid <= 1'b0;
                        wst_q   <= W_FILL;
                    end else begin
                        werr_q <= 1'b1;
                    end
                end
                W_FILL: if (bus.wr_valid) begin
                    if (wr_c_q == wn_q - dim_t'(1)) begin
                        wr_c_q <= '0;
                        if (wr_r_q == wm_q - dim_t'(1)) wst_q <= W_COMMIT;
                        else                            wr_r_q <= wr_r_q + dim_t'(1);
                    end else begin
                        wr_c_q <= wr_c_q + dim_t'(1);
                    end
                end
                W_COMMIT: begin
                    meta_q[wslot_q] <= '{valid: 1'b1, m: wm_q, n: wn_q};
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    wst_q  <= W_IDLE;
                end
                default: wst_q <= W_IDLE;
            endcase
        end
    end

    // rzero_q forces rd_elem to 0 after a bad read and out of reset; both it and
    // the RAM read register only update on an accepted request, so rd_elem holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_q    <= R_IDLE;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rzero_q  <= 1'b1;
        end else begin
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            case (rst_q)
                R_IDLE: if (bus.rd_en) begin
                    rvalid_q <= 1'b1;
                    rerr_q   <= rd_bad;
                    rzero_q  <= rd_bad;
                    rst_q    <= R_RESP;
                end
                R_RESP:  rst_q <= R_HOLD;
                R_HOLD:  if (!bus.rd_en) rst_q <= R_IDLE;
                default: rst_q <= R_IDLE;
            endcase
        end
    end

    assign bus.wr_busy       = busy_q;
    assign bus.wr_done       = done_q;
    assign bus.wr_err        = werr_q;
    assign bus.rd_elem       = rzero_q ? '0 : ram_rdata;
    assign bus.rd_elem_valid = rvalid_q;
    assign bus.rd_err        = rerr_q;
    assign bus.slot0_valid   = meta_q[0].valid;
    assign bus.slot0_m       = meta_q[0].m;
    assign bus.slot0_n       = meta_q[0].n;
    assign bus.slot1_valid   = meta_q[1].valid;
    assign bus.slot1_m       = meta_q[1].m;
    assign bus.slot1_n       = meta_q[1].n;
endmodule

// File: tb/tb_mat_store.sv
// Randomised bench for mat_store against a per-slot array model of loads and reads.
module tb_mat_store;
    import mat_store_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mat_store_if bus();
    mat_store dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    // reference model: contents and committed state of each slot
    int mmem [2][SLOT_DEPTH];
    bit mv [2];
    int mm [2];
    int mn [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk_slots();
        check("slot0_valid", 32'(bus.slot0_valid), 32'(mv[0]));
        check("slot0_m", 32'(bus.slot0_m), mm[0]);
        check("slot0_n", 32'(bus.slot0_n), mn[0]);
        check("slot1_valid", 32'(bus.slot1_valid), 32'(mv[1]));
        check("slot1_m", 32'(bus.slot1_m), mm[1]);
        check("slot1_n", 32'(bus.slot1_n), mn[1]);
    endtask

    task automatic chk_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.wr_busy), 0);
        check({tag, "_done"}, 32'(bus.wr_done), 0);
        check({tag, "_werr"}, 32'(bus.wr_err), 0);
        check({tag, "_rvalid"}, 32'(bus.rd_elem_valid), 0);
        check({tag, "_rerr"}, 32'(bus.rd_err), 0);
        check({tag, "_relem"}, 32'(bus.rd_elem), 0);
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            mv[s] = 1'b0;
            mm[s] = 0;
            mn[s] = 0;
        end
    endtask

    task automatic load(input logic s, input int m, input int n, input int base, input bit rnd);
        int v;
        int lat;
        @(negedge clk);
        bus.wr_start = 1'b1;
        bus.wr_slot  = s;
        bus.wr_m     = dim_t'(m);
        bus.wr_n     = dim_t'(n);
        mv[s] = 1'b0;
        @(negedge clk);
        bus.wr_start = 1'b0;
        check("wr_busy_start", 32'(bus.wr_busy), 1);
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                if (rnd && $urandom_range(0, 3) == 0) begin
                    bus.wr_valid = 1'b0;
                    @(negedge clk);
                end
                v = rnd ? int'($urandom_range(0, 255)) : base + r * n + c;
                bus.wr_valid = 1'b1;
                bus.wr_elem  = elem_t'(v);
                mmem[s][r * MAX_DIM + c] = v;
                @(negedge clk);
            end
        end
        bus.wr_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.wr_done) begin
                lat = i;
                break;
            end
        end
        check("wr_done_lat", lat, 1);
        mv[s] = 1'b1;
        mm[s] = m;
        mn[s] = n;
        chk_slots();
        check("wr_busy_end", 32'(bus.wr_busy), 0);
        @(negedge clk);
        check("wr_done_pulse", 32'(bus.wr_done), 0);
    endtask

    task automatic bad_start(input logic s, input int m, input int n);
        @(negedge clk);
        bus.wr_start = 1'b1;
        bus.wr_slot  = s;
        bus.wr_m     = dim_t'(m);
        bus.wr_n     = dim_t'(n);
        @(negedge clk);
        bus.wr_start = 1'b0;
        check("wr_err_pulse", 32'(bus.wr_err), 1);
        check("wr_err_busy", 32'(bus.wr_busy), 0);
        @(negedge clk);
        check("wr_err_clear", 32'(bus.wr_err), 0);
        check("wr_err_busy2", 32'(bus.wr_busy), 0);
        chk_slots();
    endtask

    task automatic rd(input logic s, input int row, input int col, input int cm, input int cn, input int hold);
        bit bad;
        int ex;
        int lat;
        logic [31:0] got;
        bad = !mv[s] || row >= mm[s] || col >= mn[s] || cm != mm[s] || cn != mn[s];
        ex  = bad ? 0 : mmem[s][row * MAX_DIM + col];
        @(negedge clk);
        bus.rd_en        = 1'b1;
        bus.rd_slot_idx  = s;
        bus.rd_row_idx   = dim_t'(row);
        bus.rd_col_idx   = dim_t'(col);
        bus.rd_current_m = dim_t'(cm);
        bus.rd_current_n = dim_t'(cn);
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.rd_elem_valid) begin
                lat = i;
                break;
            end
        end
        check("rd_lat", lat, 1);
        check("rd_elem", 32'(bus.rd_elem), ex);
        check("rd_err", 32'(bus.rd_err), 32'(bad));
        got = 32'(bus.rd_elem);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rd_single", 32'(bus.rd_elem_valid), 0);
            check("rd_err_low", 32'(bus.rd_err), 0);
            check("rd_hold", 32'(bus.rd_elem), got);
        end
        bus.rd_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_start = 0; bus.wr_slot = 0; bus.wr_m = '0; bus.wr_n = '0;
        bus.wr_valid = 0; bus.wr_elem = '0;
        bus.rd_en = 0; bus.rd_slot_idx = 0; bus.rd_row_idx = '0; bus.rd_col_idx = '0;
        bus.rd_current_m = '0; bus.rd_current_n = '0;
        model_clear();

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk_slots();
        rst_n = 1'b1;
        @(negedge clk);

        // basic load and read-back
        load(1'b0, 2, 3, 1, 1'b0);
        rd(1'b0, 1, 2, 2, 3, 0);
        // held request answers once; re-assertion answers again
        rd(1'b0, 0, 0, 2, 3, 4);
        rd(1'b0, 0, 0, 2, 3, 0);
        // bad reads
        rd(1'b1, 0, 0, 0, 0, 0);
        rd(1'b0, 2, 0, 2, 3, 0);
        rd(1'b0, 0, 0, 2, 4, 0);
        // illegal dimensions
        bad_start(1'b1, 0, 3);
        bad_start(1'b0, 2, 6);

        // reads during a load of the other slot
        load(1'b1, 1, 1, 7, 1'b0);
        fork
            load(1'b0, 3, 3, 10, 1'b0);
            begin
                @(negedge clk);
                rd(1'b1, 0, 0, 1, 1, 0);
                rd(1'b0, 0, 0, 3, 3, 0);
            end
        join
        rd(1'b0, 2, 2, 3, 3, 0);
        check("reload_elem", 32'(mmem[0][2 * MAX_DIM + 2]), 18);

        // reset in the middle of a load
        @(negedge clk);
        bus.wr_start = 1'b1; bus.wr_slot = 1'b0; bus.wr_m = 3'd3; bus.wr_n = 3'd3;
        mv[0] = 1'b0;
        @(negedge clk);
        bus.wr_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_elem  = elem_t'(100 + k);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk_idle_outputs("midrst");
        chk_slots();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(1'b0, 0, 0, 3, 3, 0);

        // randomised mix of loads, illegal starts and reads
        for (int it = 0; it < 40; it++) begin
            int op;
            logic s;
            op = int'($urandom_range(0, 9));
            s  = 1'($urandom_range(0, 1));
            if (op < 3) begin
                load(s, int'($urandom_range(1, MAX_DIM)), int'($urandom_range(1, MAX_DIM)), 0, 1'b1);
            end else if (op == 3) begin
                if ($urandom_range(0, 1) == 0) bad_start(s, 0, int'($urandom_range(1, 7)));
                else                           bad_start(s, int'($urandom_range(1, 5)), int'($urandom_range(6, 7)));
            end else begin
                int cm;
                int cn;
                cm = mm[s];
                cn = mn[s];
                if ($urandom_range(0, 9) < 3) begin
                    cm = int'($urandom_range(0, 6));
                    cn = int'($urandom_range(0, 6));
                end
                rd(s, int'($urandom_range(0, MAX_DIM)), int'($urandom_range(0, MAX_DIM)), cm, cn,
                   int'($urandom_range(0, 2)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
